// File: rtl/imem_loader.sv
// Instruction memory boot/reload controller: packs a host byte stream big-endian
// into 32-bit words and writes them to imem while holding the CPU stalled.
module imem_loader #(
  parameter int n       = 32,
  parameter int r       = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [r:0]   load_len,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  input  logic [r-1:0] cpu_addr,
  output logic [r-1:0] imem_addr,
  output logic         we,
  output logic [n-1:0] wdata,
  output logic         cpu_stall,
  output logic         done,
  output logic         error,
  output logic [r:0]   loaded_words
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam int            TW      = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [r:0]    DEPTH   = {1'b1, {r{1'b0}}};

  logic [1:0]    state;
  logic [r-1:0]  waddr;
  logic [1:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [r:0]    len;
  logic [r:0]    len_clamp;

  assign len_clamp = (load_len > DEPTH) ? DEPTH : load_len;

  // Handshake and status outputs are pure functions of state, so they take
  // their reset values the instant the state register resets.
  assign byte_ready = (state == LOAD);
  assign we         = (state == WRITE);
  assign cpu_stall  = (state != RUN);
  assign error      = (state == ERROR);
  assign imem_addr  = (state == LOAD || state == WRITE) ? waddr : cpu_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      waddr        <= '0;
      bcnt         <= '0;
      tcnt         <= '0;
      len          <= '0;
      wdata        <= '0;
      done         <= 1'b0;
      loaded_words <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN, ERROR: begin
          if (start) begin
            len          <= len_clamp;
            waddr        <= '0;
            bcnt         <= '0;
            tcnt         <= '0;
            loaded_words <= '0;
            if (len_clamp == '0) begin
              done  <= 1'b1;
              state <= RUN;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (byte_valid) begin
            // first byte of each word lands in the MSB
            case (bcnt)
              2'd0:    wdata[31:24] <= byte_data;
              2'd1:    wdata[23:16] <= byte_data;
              2'd2:    wdata[15:8]  <= byte_data;
              default: wdata[7:0]   <= byte_data;
            endcase
            bcnt <= bcnt + 1'b1;
            tcnt <= '0;
            if (bcnt == 2'd3) state <= WRITE;
          end else if (tcnt == TO_LAST) begin
            state <= ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WRITE: begin
          loaded_words <= loaded_words + 1'b1;
          tcnt         <= '0;
          if ({1'b0, waddr} == len - 1'b1) begin
            state <= RUN;
            done  <= 1'b1;
          end else begin
            waddr <= waddr + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-level load model.
module tb_imem_loader;
  localparam int R  = 6;
  localparam int TO = 1024;

  logic          clk = 0;
  logic          reset;
  logic          start;
  logic [R:0]    load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [R-1:0]  cpu_addr;
  logic [R-1:0]  imem_addr;
  logic          we;
  logic [31:0]   wdata;
  logic          cpu_stall;
  logic          done;
  logic          error;
  logic [R:0]    loaded_words;

  imem_loader #(.n(32), .r(R), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .cpu_addr(cpu_addr), .imem_addr(imem_addr), .we(we), .wdata(wdata),
    .cpu_stall(cpu_stall), .done(done), .error(error), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int hang   = 0;

  // observed imem writes and pulses
  logic [R-1:0] wa_q[$];
  logic [31:0]  wd_q[$];
  int done_cnt, br_bad, stall_done_bad;

  // model: words the host intends to land in imem, in order
  logic [31:0] exp_w[$];

  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(wdata);
      if (byte_ready) br_bad++;
    end
    if (done) begin
      done_cnt++;
      if (cpu_stall) stall_done_bad++;
    end
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); exp_w.delete();
    done_cnt = 0; br_bad = 0; stall_done_bad = 0; hang = 0;
  endtask

  task automatic do_start(input int req);
    start = 1; load_len = (R+1)'(req);
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    byte_valid = 1; byte_data = b;
    while (!byte_ready && k < 100) begin @(negedge clk); k++; end
    if (!byte_ready) hang++;
    @(negedge clk);
  endtask

  task automatic send_words(input int nw, input int gapmax);
    logic [31:0] w;
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      exp_w.push_back(w);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8]);
        if (gapmax > 0) begin
          byte_valid = 0;
          repeat ($urandom_range(0, gapmax)) @(negedge clk);
        end
      end
    end
    byte_valid = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cpu_stall && k < 500) begin @(negedge clk); k++; end
    if (cpu_stall) hang++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    cpu_addr = 6'd5;
    @(negedge clk);
    checks++; if (imem_addr !== 6'd5) begin fails++; $display("FAIL reset_imem_addr: got %0d expected 5", imem_addr); end
    checks++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    checks++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", we); end
    checks++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset_byte_ready: got %b expected 0", byte_ready); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_done_error: got %b%b expected 00", done, error); end
    checks++; if (loaded_words !== 0 || wdata !== 0) begin fails++; $display("FAIL reset_regs: got lw=%0d wdata=%h expected 0/0", loaded_words, wdata); end
  endtask

  task automatic test_basic();
    logic [7:0] bs [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    clear_mon();
    exp_w.push_back(32'h12345678); exp_w.push_back(32'h9ABCDEF0);
    do_start(2);
    checks++; if (cpu_stall !== 1'b1 || byte_ready !== 1'b1) begin fails++; $display("FAIL basic_load_entry: got stall=%b ready=%b expected 1/1", cpu_stall, byte_ready); end
    for (int i = 0; i < 8; i++) send_byte(bs[i]);
    byte_valid = 0;
    wait_idle();
    checks++; if (wa_q.size() != 2) begin fails++; $display("FAIL basic_nwrites: got %0d expected 2", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 2; i++) begin
      checks++; if (wa_q[i] !== 6'(i) || wd_q[i] !== exp_w[i]) begin fails++; $display("FAIL basic_write%0d: got %0d:%h expected %0d:%h", i, wa_q[i], wd_q[i], i, exp_w[i]); end
    end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
    checks++; if (loaded_words !== 7'd2) begin fails++; $display("FAIL basic_loaded: got %0d expected 2", loaded_words); end
    checks++; if (br_bad != 0 || stall_done_bad != 0 || hang != 0) begin fails++; $display("FAIL basic_handshake: got br=%0d sd=%0d hang=%0d expected 0", br_bad, stall_done_bad, hang); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    do_start(0);
    checks++; if (done !== 1'b1 || cpu_stall !== 1'b0) begin fails++; $display("FAIL zero_done: got done=%b stall=%b expected 1/0", done, cpu_stall); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != 1 || wa_q.size() != 0) begin fails++; $display("FAIL zero_after: got done=%0d writes=%0d expected 1/0", done_cnt, wa_q.size()); end
  endtask

  task automatic test_random();
    int req, nw, bad;
    for (int t = 0; t < 5; t++) begin
      clear_mon();
      req = $urandom_range(1, 12);
      nw = req;
      cpu_addr = 6'($urandom);
      do_start(req);
      send_words(nw, 3);
      wait_idle();
      bad = 0;
      if (wa_q.size() != nw) bad++;
      else for (int i = 0; i < nw; i++) if (wa_q[i] !== 6'(i) || wd_q[i] !== exp_w[i]) bad++;
      checks++; if (bad != 0) begin fails++; $display("FAIL random_writes len=%0d: got %0d writes, %0d bad expected %0d, 0 bad", req, wa_q.size(), bad, nw); end
      checks++; if (done_cnt != 1 || loaded_words !== 7'(nw) || imem_addr !== cpu_addr) begin fails++; $display("FAIL random_end len=%0d: got done=%0d lw=%0d ia=%0d expected 1/%0d/%0d", req, done_cnt, loaded_words, imem_addr, nw, cpu_addr); end
    end
  endtask

  task automatic test_clamp();
    int bad = 0;
    clear_mon();
    do_start(100);
    send_words(64, 0);
    wait_idle();
    if (wa_q.size() != 64) bad++;
    else for (int i = 0; i < 64; i++) if (wa_q[i] !== 6'(i) || wd_q[i] !== exp_w[i]) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL clamp_writes: got %0d writes, %0d bad expected 64, 0 bad", wa_q.size(), bad); end
    checks++; if (done_cnt != 1 || loaded_words !== 7'd64) begin fails++; $display("FAIL clamp_end: got done=%0d lw=%0d expected 1/64", done_cnt, loaded_words); end
    checks++; if (br_bad != 0 || stall_done_bad != 0 || hang != 0) begin fails++; $display("FAIL clamp_handshake: got br=%0d sd=%0d hang=%0d expected 0", br_bad, stall_done_bad, hang); end
  endtask

  task automatic test_timeout();
    clear_mon();
    do_start(1);
    send_byte(8'hAA); send_byte(8'hBB);
    byte_valid = 0;
    repeat (TO - 1) @(negedge clk);
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL timeout_early: got error=%b expected 0", error); end
    @(negedge clk);
    checks++; if (error !== 1'b1 || cpu_stall !== 1'b1 || byte_ready !== 1'b0) begin fails++; $display("FAIL timeout_err: got e=%b s=%b r=%b expected 1/1/0", error, cpu_stall, byte_ready); end
    byte_valid = 1; byte_data = 8'h55;
    repeat (3) @(negedge clk);
    byte_valid = 0;
    checks++; if (error !== 1'b1 || wa_q.size() != 0 || done_cnt != 0) begin fails++; $display("FAIL timeout_hold: got e=%b writes=%0d done=%0d expected 1/0/0", error, wa_q.size(), done_cnt); end
    do_start(1);
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL timeout_clear: got error=%b expected 0", error); end
    send_words(1, 0);
    wait_idle();
    checks++; if (wa_q.size() != 1 || wd_q[0] !== exp_w[0] || wa_q[0] !== 6'd0) begin fails++; $display("FAIL timeout_reload: got %0d writes expected 1 at 0 = %h", wa_q.size(), exp_w[0]); end
    checks++; if (done_cnt != 1 || loaded_words !== 7'd1) begin fails++; $display("FAIL timeout_done: got done=%0d lw=%0d expected 1/1", done_cnt, loaded_words); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w1 = $urandom;
    int bad = 0;
    clear_mon();
    exp_w.push_back(w1);
    do_start(2);
    send_byte(w1[31:24]); send_byte(w1[23:16]);
    byte_valid = 0;
    do_start(0);
    do_start(1);
    send_byte(w1[15:8]); send_byte(w1[7:0]);
    send_words(1, 0);
    wait_idle();
    if (wa_q.size() != 2) bad++;
    else for (int i = 0; i < 2; i++) if (wa_q[i] !== 6'(i) || wd_q[i] !== exp_w[i]) bad++;
    checks++; if (bad != 0 || done_cnt != 1) begin fails++; $display("FAIL start_ignored: got %0d writes %0d bad done=%0d expected 2/0/1", wa_q.size(), bad, done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    cpu_addr = 6'd17;
    do_start(4);
    send_words(2, 0);
    send_byte(8'h11); send_byte(8'h22);
    byte_valid = 0;
    #2 reset = 1;
    #1;
    checks++; if (cpu_stall !== 1'b0 || byte_ready !== 1'b0 || we !== 1'b0) begin fails++; $display("FAIL midreset_ctl: got s=%b r=%b we=%b expected 000", cpu_stall, byte_ready, we); end
    checks++; if (done !== 1'b0 || error !== 1'b0 || loaded_words !== 0 || wdata !== 0) begin fails++; $display("FAIL midreset_regs: got d=%b e=%b lw=%0d wd=%h expected 0", done, error, loaded_words, wdata); end
    checks++; if (imem_addr !== 6'd17) begin fails++; $display("FAIL midreset_addr: got %0d expected 17", imem_addr); end
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    checks++; if (wa_q.size() != 2 || cpu_stall !== 1'b0) begin fails++; $display("FAIL midreset_after: got writes=%0d stall=%b expected 2/0", wa_q.size(), cpu_stall); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; load_len = '0; byte_valid = 0; byte_data = '0; cpu_addr = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_random();
    test_clamp();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
